// File: rtl/sram_pkg.sv
// Shared constants and types for the 1K x 12 single-port SRAM.
package sram_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset zero-fill sweep: walks every address once, then drops busy_o.
// Compiled only when INIT_CLEAR_EN is defined.
`ifdef INIT_CLEAR_EN
module sram_clear_seq
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o
);

  addr_t cnt_q, cnt_d;
  logic  busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == addr_t'(DEPTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign clr_addr_o = cnt_q;
  assign busy_o     = busy_q;

endmodule
`endif

// File: rtl/sram_1k_x12.sv
// 1024 x 12 single-port synchronous SRAM on a shared tri-state data bus.
// Optional INIT_CLEAR_EN zero-fills the array after every reset release.
module sram_1k_x12
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              re,
  input  logic              we,
  inout  wire  [DATA_W-1:0] data
);

  word_t mem [DEPTH];

  word_t rd_q, rd_d;
  logic  rd_vld_q, rd_vld_d;

  logic  sweep_c;
  addr_t clr_addr_c;
  logic  wr_en_c;
  addr_t wr_addr_c;
  word_t wr_data_c;
  logic  rd_en_c;
  logic  drive_c;

`ifdef INIT_CLEAR_EN
  sram_clear_seq u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_addr_o (clr_addr_c),
    .busy_o     (sweep_c)
  );
`else
  assign sweep_c    = 1'b0;
  assign clr_addr_c = '0;
`endif

  // Write wins over read; the sweep owns the array while it runs.
  always_comb begin
    wr_en_c   = sweep_c | we;
    wr_addr_c = sweep_c ? clr_addr_c : address;
    wr_data_c = sweep_c ? '0 : data;
    rd_en_c   = !sweep_c && re && !we;
    rd_d      = rd_q;
    rd_vld_d  = rd_vld_q;
    if (rd_en_c) begin
      rd_d     = mem[address];
      rd_vld_d = 1'b1;
    end
  end

  // Array is never cleared by reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign drive_c = re && !we && rd_vld_q && !sweep_c;
  assign data    = drive_c ? rd_q : 'z;

endmodule

// File: tb/tb_sram_1k_x12.sv
// Scoreboard bench for sram_1k_x12; the bus is pulled up so a released bus reads all ones.
module tb_sram_1k_x12;
  import sram_pkg::*;

  localparam logic [DATA_W-1:0] REL = 12'hFFF;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              re      = 1'b1;
  logic              we      = 1'b0;
  logic              tb_en   = 1'b0;
  logic [DATA_W-1:0] tb_val  = '0;
  tri1  [DATA_W-1:0] data;

  assign data = tb_en ? tb_val : 'z;

  sram_1k_x12 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .re      (re),
    .we      (we),
    .data    (data)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned       at;
    logic [DATA_W-1:0] want;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: bus=%h want=%h", name, act, want);
    end
  endtask

  // Monitor: compare the bus half a cycle after each edge that has an expectation.
  exp_t cur;
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
        cur = sb.pop_front();
        if (cur.at != edge_cnt) check({cur.name, "_missed"}, data, ~cur.want);
        else                    check(cur.name, data, cur.want);
      end
    end
  end

  task automatic step(input logic r, input logic w, input int unsigned a,
                      input logic [DATA_W-1:0] d);
    @(negedge clk);
    #1;
    re      = r;
    we      = w;
    address = ADDR_W'(a);
    tb_en   = w;
    tb_val  = d;
  endtask

  task automatic expect_bus(input string n, input logic [DATA_W-1:0] v);
    exp_t e;
    e.at   = edge_cnt + 1;
    e.want = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wait_init();
`ifdef INIT_CLEAR_EN
    re    = 1'b0;
    we    = 1'b0;
    tb_en = 1'b0;
    repeat (DEPTH + 4) @(negedge clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with re high: bus released.
    repeat (2) @(negedge clk);
    #1;
    check("reset_bus", data, REL);
    rst_n = 1'b1;
    re    = 1'b0;
    wait_init();

    for (int k = 0; k <= 10; k++) begin
      step(1'b0, 1'b1, 12 * k, DATA_W'(99 * k));
      expect_bus($sformatf("wr_%0d", k), DATA_W'(99 * k));
    end
    for (int k = 0; k <= 10; k++) begin
      step(1'b1, 1'b0, 12 * k, '0);
      expect_bus($sformatf("rd_%0d", k), DATA_W'(99 * k));
    end
    step(1'b0, 1'b0, 0, '0);
    expect_bus("idle_z", REL);

    // Collision: rd_q holds ABC so any RAM drive would corrupt the bench value.
    step(1'b0, 1'b1, 5, 12'hABC); expect_bus("coll_wr", 12'hABC);
    step(1'b1, 1'b0, 5, '0);      expect_bus("coll_pre_rd", 12'hABC);
    step(1'b1, 1'b1, 5, 12'h123); expect_bus("coll_both", 12'h123);
    step(1'b1, 1'b0, 5, '0);      expect_bus("coll_rd", 12'h123);

    step(1'b0, 1'b1, 1023, 12'hFFF); expect_bus("hi_wr", 12'hFFF);
    step(1'b0, 1'b1, 0, 12'h001);    expect_bus("lo_wr", 12'h001);
    step(1'b1, 1'b0, 1023, '0);      expect_bus("hi_rd", 12'hFFF);
    step(1'b1, 1'b0, 0, '0);         expect_bus("lo_rd", 12'h001);

    // Async reset between edges while a read is driving the bus.
    step(1'b1, 1'b0, 36, '0);
    expect_bus("pre_rst_rd", 12'h129);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", data, REL);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_no_vld", data, REL);
`ifdef INIT_CLEAR_EN
    expect_bus("sweep_rd_ignored", REL);
    wait_init();
    step(1'b1, 1'b0, 36, '0);
    expect_bus("post_rst_rd", 12'h000);
`else
    expect_bus("post_rst_rd", 12'h129);
`endif

`ifdef INIT_CLEAR_EN
    step(1'b0, 1'b1, 300, 12'h555); expect_bus("clr_wr300", 12'h555);
    step(1'b0, 1'b1, 2, 12'h666);   expect_bus("clr_wr2", 12'h666);
    step(1'b0, 1'b0, 0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) step(1'b0, 1'b0, 0, '0);
    step(1'b0, 1'b1, 2, 12'h777);   expect_bus("sweep_wr_bus", 12'h777);
    step(1'b1, 1'b0, 300, '0);      expect_bus("sweep_rd_z", REL);
    wait_init();
    step(1'b1, 1'b0, 300, '0);      expect_bus("clr_rd300", 12'h000);
    step(1'b1, 1'b0, 2, '0);        expect_bus("clr_rd2", 12'h000);
`endif

    step(1'b0, 1'b0, 0, '0);
    expect_bus("final_idle", REL);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
